// File: rtl/ofs_axi_split_pkg.sv
// Shared types and constants for the AXI AR burst splitter.
package ofs_axi_split_pkg;

  // Width of the remaining-beat counter: a full AXI4 burst is 256 beats.
  localparam int REM_W = 9;

  // log2 of the default 64-byte beat. Parameterised modules compute their own
  // shift from DATA_BYTES.
  localparam int BEAT_SHIFT = 6;

  // One upstream read command at the default widths.
  typedef struct packed {
    logic [47:0] addr;
    logic [7:0]  len;
    logic [8:0]  id;
  } ar_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // True when x is a positive power of two.
  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/ofs_axi_chunk_calc.sv
// Combinational chunk sizing: given a start address and the beats still
// owed, returns the size of the next chunk and where the following one starts.
module ofs_axi_chunk_calc
  import ofs_axi_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_BYTES = 64,
  parameter int MAX_BEATS  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REM_W-1:0]      rem_beats,
  output logic [7:0]            chunk_len,
  output logic [REM_W-1:0]      chunk_beats,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  is_last
);

  localparam int BEAT_SH   = $clog2(DATA_BYTES);
  localparam int BND_BEATS = BOUNDARY / DATA_BYTES;

  logic [ADDR_WIDTH-1:0] offs_beats;
  logic [ADDR_WIDTH-1:0] btb;
  logic [REM_W-1:0]      beats;

  // Clamp the chunk to the remaining count, the burst cap and the next boundary.
  always_comb begin
    offs_beats = (addr & ADDR_WIDTH'(BOUNDARY - 1)) >> BEAT_SH;
    btb        = ADDR_WIDTH'(BND_BEATS) - offs_beats;
    beats      = rem_beats;
    if (beats > REM_W'(MAX_BEATS)) beats = REM_W'(MAX_BEATS);
    // btb is below beats here, so it fits the narrower counter.
    if (ADDR_WIDTH'(beats) > btb) beats = REM_W'(btb);
    chunk_beats = beats;
    chunk_len   = 8'(beats - REM_W'(1));
    is_last     = (beats == rem_beats);
    // Later chunks always start beat-aligned, so the low bits are dropped here.
    next_addr   = (addr & ~ADDR_WIDTH'(DATA_BYTES - 1))
                + (ADDR_WIDTH'(beats) << BEAT_SH);
  end

endmodule

// File: rtl/ofs_axi_ar_splitter.sv
// AXI4 AR burst splitter: breaks one read command into chunks of at most
// MAX_BEATS beats that never cross a BOUNDARY-byte line, tagging the final one.
module ofs_axi_ar_splitter
  import ofs_axi_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int ID_WIDTH   = 9,
  parameter int DATA_BYTES = 64,
  parameter int MAX_BEATS  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [ID_WIDTH-1:0]   s_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic                  m_arlast
);

  if (!is_pow2(DATA_BYTES)) begin : g_chk_db
    $error("DATA_BYTES must be a power of 2");
  end
  if (!is_pow2(MAX_BEATS) || MAX_BEATS > 256) begin : g_chk_mb
    $error("MAX_BEATS must be a power of 2 in 1..256");
  end
  if (!is_pow2(BOUNDARY) || BOUNDARY < DATA_BYTES) begin : g_chk_bnd
    $error("BOUNDARY must be a power of 2 no smaller than DATA_BYTES");
  end

  state_e                state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  m_arvalid_q, m_arvalid_d;
  logic [ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
  logic [7:0]            m_arlen_q, m_arlen_d;
  logic [ID_WIDTH-1:0]   m_arid_q, m_arid_d;
  logic                  m_arlast_q, m_arlast_d;

  logic                  slot_free;
  logic                  load;
  logic [ADDR_WIDTH-1:0] calc_addr;
  logic [REM_W-1:0]      calc_rem;
  logic [ID_WIDTH-1:0]   calc_id;
  logic [7:0]            calc_len;
  logic [REM_W-1:0]      calc_beats;
  logic [ADDR_WIDTH-1:0] calc_next;
  logic                  calc_last;

  // The single chunk calculator sees the new command in IDLE, the saved tail in SPLIT.
  always_comb begin
    if (state_q == IDLE) begin
      calc_addr = s_araddr;
      calc_rem  = {1'b0, s_arlen} + REM_W'(1);
      calc_id   = s_arid;
    end else begin
      calc_addr = next_addr_q;
      calc_rem  = rem_q;
      calc_id   = id_q;
    end
  end

  ofs_axi_chunk_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_BYTES (DATA_BYTES),
    .MAX_BEATS  (MAX_BEATS),
    .BOUNDARY   (BOUNDARY)
  ) u_calc (
    .addr        (calc_addr),
    .rem_beats   (calc_rem),
    .chunk_len   (calc_len),
    .chunk_beats (calc_beats),
    .next_addr   (calc_next),
    .is_last     (calc_last)
  );

  // FSM outputs: upstream ready only when idle with a free output slot.
  always_comb begin
    slot_free = ~m_arvalid_q | m_arready;
    s_arready = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        s_arready = slot_free;
        load      = s_arvalid & slot_free;
      end
      SPLIT: begin
        load = slot_free;
      end
      default: ;
    endcase
  end

  // FSM next state: stay in SPLIT until the last chunk is loaded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load && !calc_last) state_d = SPLIT;
      SPLIT:   if (load && calc_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output slot and split bookkeeping: reload on load, drain on handshake.
  always_comb begin
    m_arvalid_d = m_arvalid_q & ~m_arready;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    m_arid_d    = m_arid_q;
    m_arlast_d  = m_arlast_q;
    rem_d       = rem_q;
    next_addr_d = next_addr_q;
    id_d        = id_q;
    if (load) begin
      m_arvalid_d = 1'b1;
      m_araddr_d  = calc_addr;
      m_arlen_d   = calc_len;
      m_arid_d    = calc_id;
      m_arlast_d  = calc_last;
      rem_d       = calc_rem - calc_beats;
      next_addr_d = calc_next;
      id_d        = calc_id;
    end
  end

  // All state, including the output registers, clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      next_addr_q <= '0;
      id_q        <= '0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      m_arid_q    <= '0;
      m_arlast_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      next_addr_q <= next_addr_d;
      id_q        <= id_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      m_arid_q    <= m_arid_d;
      m_arlast_q  <= m_arlast_d;
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arid    = m_arid_q;
  assign m_arlast  = m_arlast_q;

endmodule
